// File: rtl/nand_page_buf_reader.sv
// -----------------------------------------------------------------------------
// nand_page_buf_reader
//
// Read-side streamer for the 1024x32 two-port NAND page buffer. On a start
// command it fetches words from the buffer's registered read port and emits
// them as a byte stream, least significant byte first.
//
// Ports:
//   CLK, RST      clock (rising edge) and synchronous active-high reset
//   start         one-cycle command pulse, only honoured while idle
//   base_addr     first word address, captured with start
//   byte_count    bytes to emit, captured with start (0 = none, clamped to
//                 MAX_BYTES)
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle completion pulse
//   RADDR         registered read address to the page buffer
//   RD            page buffer read data, valid one cycle after RADDR
//   m_data        stream byte
//   m_valid       stream byte valid
//   m_ready       downstream accept
//   m_last        final byte of the command
//   csum          (NAND_PAGE_RD_CHECKSUM_EN only) XOR of every byte accepted
//                 in the current command
//
// Optional feature macro: NAND_PAGE_RD_CHECKSUM_EN adds the csum output.
//
// Stream handshake: a byte transfers on a rising edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data, m_last and m_valid
// stay unchanged until that transfer happens; m_valid never depends on
// m_ready.
// -----------------------------------------------------------------------------
module nand_page_buf_reader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BYTES = 2112
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [11:0]       byte_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [31:0]       RD,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef NAND_PAGE_RD_CHECKSUM_EN
  ,
  output logic [7:0]        csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_raddr;
  logic [11:0]       r_remain;      // bytes still to hand over
  logic [11:0]       r_words_left;  // words still to issue on RADDR
  logic [31:0]       r_shift;       // word being serialised
  logic              r_shift_vld;
  logic [1:0]        r_byte_idx;    // byte position inside r_shift word
  logic [31:0]       r_pf;          // one-word prefetch holding register
  logic              r_pf_vld;
  // Read pipeline tracking: r_iss marks a cycle in which RADDR carries a
  // freshly issued address; r_rdv marks the following cycle, when RD holds
  // that word and must be captured.
  logic              r_iss;
  logic              r_rdv;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic [11:0] w_cnt_clamp;
  logic [12:0] w_cnt_sum;
  logic [11:0] w_words_m1;
  logic        w_active;
  logic        w_hs;
  logic        w_word_end;
  logic        w_final;
  logic [2:0]  w_occ;
  logic        w_issue;
  logic        w_shift_free;

  always_comb begin
    w_cnt_clamp  = (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
    // Words needed = ceil(bytes/4); the first one is issued with start.
    w_cnt_sum    = {1'b0, w_cnt_clamp} + 13'd3;
    w_words_m1   = 12'(w_cnt_sum >> 2) - 12'd1;
    w_active     = (r_state == S_FETCH) || (r_state == S_STREAM);
    w_hs         = r_shift_vld && m_ready;
    w_word_end   = w_hs && (r_byte_idx == 2'd3);
    w_final      = w_hs && (r_remain == 12'd1);
    // Words either in flight or parked; the shift register and the prefetch
    // register give room for two, so never let more than two be owed.
    w_occ        = {2'b00, r_iss} + {2'b00, r_rdv} +
                   {2'b00, r_pf_vld} + {2'b00, r_shift_vld};
    w_issue      = w_active && !w_final && (r_words_left != 12'd0) &&
                   (w_occ < 3'd2);
    w_shift_free = !r_shift_vld || w_word_end;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_raddr      <= '0;
      r_remain     <= '0;
      r_words_left <= '0;
      r_shift      <= '0;
      r_shift_vld  <= 1'b0;
      r_byte_idx   <= '0;
      r_pf         <= '0;
      r_pf_vld     <= 1'b0;
      r_iss        <= 1'b0;
      r_rdv        <= 1'b0;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
            r_csum <= '0;
`endif
            if (w_cnt_clamp == 12'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_FETCH;
              r_raddr      <= base_addr;
              r_remain     <= w_cnt_clamp;
              r_words_left <= w_words_m1;
              r_iss        <= 1'b1;
              r_rdv        <= 1'b0;
              r_shift_vld  <= 1'b0;
              r_pf_vld     <= 1'b0;
              r_byte_idx   <= '0;
            end
          end
        end

        S_FETCH, S_STREAM: begin
          if (w_final) begin
            // Last byte accepted: anything prefetched or still in flight
            // belongs to unused word tail or beyond and is dropped.
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_remain     <= '0;
            r_words_left <= '0;
            r_shift_vld  <= 1'b0;
            r_pf_vld     <= 1'b0;
            r_iss        <= 1'b0;
            r_rdv        <= 1'b0;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
            r_csum       <= r_csum ^ r_shift[7:0];
`endif
          end else begin
            r_rdv <= r_iss;
            r_iss <= w_issue;
            if (w_issue) begin
              r_raddr      <= r_raddr + ADDR_W'(1);
              r_words_left <= r_words_left - 12'd1;
            end

            if (w_hs) begin
              r_remain   <= r_remain - 12'd1;
              r_shift    <= {8'h00, r_shift[31:8]};
              r_byte_idx <= r_byte_idx + 2'd1;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
              r_csum     <= r_csum ^ r_shift[7:0];
`endif
            end

            // Refill order: prefetched word first, then the word arriving
            // on RD this cycle; a word arriving while the shift register is
            // still busy is parked in the prefetch register.
            if (w_shift_free) begin
              if (r_pf_vld) begin
                r_shift     <= r_pf;
                r_shift_vld <= 1'b1;
                r_byte_idx  <= '0;
                r_pf_vld    <= r_rdv;
                if (r_rdv) begin
                  r_pf <= RD;
                end
                r_state     <= S_STREAM;
              end else if (r_rdv) begin
                r_shift     <= RD;
                r_shift_vld <= 1'b1;
                r_byte_idx  <= '0;
                r_state     <= S_STREAM;
              end else begin
                r_shift_vld <= 1'b0;
              end
            end else if (r_rdv) begin
              r_pf     <= RD;
              r_pf_vld <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign RADDR   = r_raddr;
  assign m_data  = r_shift[7:0];
  assign m_valid = r_shift_vld;
  assign m_last  = r_shift_vld && (r_remain == 12'd1);
`ifdef NAND_PAGE_RD_CHECKSUM_EN
  assign csum    = r_csum;
`endif

endmodule

// File: tb/tb_nand_page_buf_reader.sv
module tb_nand_page_buf_reader;

  // ---------------- clock / reset / signals ----------------
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [11:0] byte_count = '0;
  logic        busy;
  logic        done;
  logic [9:0]  RADDR;
  logic [31:0] RD;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
`ifdef NAND_PAGE_RD_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always #5 CLK = ~CLK;

  // Page buffer model: registered read port.
  logic [31:0] mem [1024];
  always_ff @(posedge CLK) RD <= mem[RADDR];

  nand_page_buf_reader #(.ADDR_W(10), .MAX_BYTES(2112)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .RADDR      (RADDR),
    .RD         (RD),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
`ifdef NAND_PAGE_RD_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  int          ready_mode = 1;   // 1: always ready, 0: random 50%
  logic [7:0]  exp_q[$];
  logic [9:0]  raddr_log[$];
  logic [7:0]  csum_model = '0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;
  logic        prev_last  = 1'b0;

  typedef struct {
    logic [9:0]  base;
    logic [11:0] count;
    int          mode;
    int          poke_at;
    int          exp_n;
    int          exp_done_idx;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected stream for the ramp pattern: word k holds bytes k..k+3.
  task automatic fill_exp(input int b, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(8'((((b + i / 4) % 1024) + (i % 4)) & 255));
  endtask

  // One clock: at the falling edge check outputs, pick m_ready for the
  // coming rising edge and retire the byte that will transfer on it.
  task automatic cyc();
    logic [7:0] e;
    @(negedge CLK);
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_last", 32'(m_last), 32'(prev_last));
    end
    m_ready = (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    if (m_valid) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(m_valid), 32'd0);
      else chk("last_flag", 32'(m_last), 32'(exp_q.size() == 1));
    end
    if (m_valid && m_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("byte", 32'(m_data), 32'(e));
      csum_model = csum_model ^ e;
      n_hs++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  // Issue one command (expected bytes already queued) and follow it to done.
  task automatic run_cmd(input logic [9:0] b, input logic [11:0] c, input int mode,
                         input int poke_at, input int exp_n, input int exp_done_idx);
    int idx;
    int first_v;
    int hs0;
    bit got_done;
    ready_mode = mode;
    hs0 = n_hs;
    first_v = -1;
    got_done = 1'b0;
    csum_model = '0;
    raddr_log.delete();
    start = 1'b1;
    base_addr = b;
    byte_count = c;
    idx = 0;
    while (!got_done && idx < 6000) begin
      cyc();
      idx++;
      if (idx == 1) chk("busy_start", 32'(busy), 32'd1);
      start = (idx == poke_at);
      if (idx == poke_at) begin
        base_addr = ~b;
        byte_count = 12'd1;
      end
      if (m_valid && first_v < 0) first_v = idx;
      if (busy && (raddr_log.size() == 0 || raddr_log[$] != RADDR)) raddr_log.push_back(RADDR);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    chk("byte_total", 32'(n_hs - hs0), 32'(exp_n));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (exp_done_idx >= 0) chk("done_cycle", 32'(idx), 32'(exp_done_idx));
    if (exp_n == 0) chk("no_valid", 32'(first_v), 32'hFFFF_FFFF);
    else if (mode == 1) chk("first_valid", 32'(first_v), 32'd3);
    chk("busy_at_done", 32'(busy), 32'd1);
`ifdef NAND_PAGE_RD_CHECKSUM_EN
    chk("csum_at_done", 32'(csum), 32'(csum_model));
`endif
    cyc();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int hs0;
    for (int k = 0; k < 1024; k++)
      mem[k] = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};

    vecs[0] = '{10'd0,    12'd2112, 1, -1, 2112, 2115};  // full page
    vecs[1] = '{10'd1022, 12'd10,   1, -1, 10,   13};    // wrap + partial word
    vecs[2] = '{10'd300,  12'd37,   0, -1, 37,   -1};    // random backpressure
    vecs[3] = '{10'd7,    12'd0,    1, -1, 0,    1};     // zero count
    vecs[4] = '{10'd0,    12'd4000, 1, -1, 2112, 2115};  // clamp
    vecs[5] = '{10'd50,   12'd23,   1, 4,  23,   26};    // start while busy
    vecs[6] = '{10'd5,    12'd6,    1, -1, 6,    9};     // 1.5 words

    // Reset values
    ready_mode = 1;
    RST = 1'b1;
    repeat (3) cyc();
    RST = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_raddr", 32'(RADDR), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
`ifdef NAND_PAGE_RD_CHECKSUM_EN
    chk("rst_csum", 32'(csum), 32'd0);
`endif

    // Table-driven commands
    for (int v = 0; v < 7; v++) begin
      fill_exp(int'(vecs[v].base), vecs[v].exp_n);
      run_cmd(vecs[v].base, vecs[v].count, vecs[v].mode, vecs[v].poke_at,
              vecs[v].exp_n, vecs[v].exp_done_idx);
    end

    // Address sequence across the 1023 -> 0 wrap
    fill_exp(1022, 10);
    run_cmd(10'd1022, 12'd10, 1, -1, 10, 13);
    chk("raddr_count", 32'(raddr_log.size()), 32'd3);
    if (raddr_log.size() == 3) begin
      chk("raddr_0", 32'(raddr_log[0]), 32'd1022);
      chk("raddr_1", 32'(raddr_log[1]), 32'd1023);
      chk("raddr_2", 32'(raddr_log[2]), 32'd0);
    end

    // Reset after the fifth byte, then a fresh command
    fill_exp(100, 20);
    ready_mode = 1;
    hs0 = n_hs;
    start = 1'b1;
    base_addr = 10'd100;
    byte_count = 12'd20;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 50 && (n_hs - hs0) < 5; k++) cyc();
    cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_raddr", 32'(RADDR), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    fill_exp(100, 20);
    run_cmd(10'd100, 12'd20, 1, -1, 20, 23);

    // start together with RST: reset wins
    RST = 1'b1;
    start = 1'b1;
    base_addr = 10'd3;
    byte_count = 12'd8;
    cyc();
    RST = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_raddr", 32'(RADDR), 32'd0);
    cyc();
    chk("rst_start_busy2", 32'(busy), 32'd0);
    chk("rst_start_valid", 32'(m_valid), 32'd0);

`ifdef NAND_PAGE_RD_CHECKSUM_EN
    mem[600] = 32'h0804_0201;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    run_cmd(10'd600, 12'd4, 1, -1, 4, 7);
    chk("csum_0f", 32'(csum), 32'h0F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
